// File: rtl/rptr_level_h_if.sv
// Read-side pointer bundle between the rclk-domain pointer handler and its consumer.
// The underflow flag exists only when RPTR_UNDERFLOW_EN is defined.
interface rptr_level_h_if #(
  parameter int PTR_WIDTH = 6
);
  logic                 r_en;
  logic [PTR_WIDTH:0]   g_wptr;
  logic [PTR_WIDTH:0]   b_rptr;
  logic [PTR_WIDTH:0]   g_rptr;
  logic                 empty;
  logic                 almost_empty;
  logic [PTR_WIDTH:0]   rd_level;
`ifdef RPTR_UNDERFLOW_EN
  logic                 underflow;

  modport master (
    output r_en, g_wptr,
    input  b_rptr, g_rptr, empty, almost_empty, rd_level, underflow
  );
  modport slave (
    input  r_en, g_wptr,
    output b_rptr, g_rptr, empty, almost_empty, rd_level, underflow
  );
`else
  modport master (
    output r_en, g_wptr,
    input  b_rptr, g_rptr, empty, almost_empty, rd_level
  );
  modport slave (
    input  r_en, g_wptr,
    output b_rptr, g_rptr, empty, almost_empty, rd_level
  );
`endif
endinterface

// File: rtl/rptr_level_h.sv
// Async-FIFO read pointer handler: syncs the writer's Gray pointer, advances the read
// pointers, registers empty/almost_empty/rd_level. Optional sticky underflow: RPTR_UNDERFLOW_EN.
module rptr_level_h #(
  parameter int PTR_WIDTH   = 6,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic          rclk,
  input  logic          rrst,
  rptr_level_h_if.slave bus
);
  localparam logic [PTR_WIDTH:0] AE_LIMIT = (PTR_WIDTH+1)'(AE_THRESH);

  logic [SYNC_STAGES-1:0][PTR_WIDTH:0] r_sync;
  logic [PTR_WIDTH:0] r_b_rptr;
  logic [PTR_WIDTH:0] r_g_rptr;
  logic [PTR_WIDTH:0] r_rd_level;
  logic               r_empty;
  logic               r_almost_empty;

  logic [PTR_WIDTH:0] w_g_wptr_s;
  logic [PTR_WIDTH:0] w_b_wptr_s;
  logic [PTR_WIDTH:0] w_b_rptr_next;
  logic [PTR_WIDTH:0] w_g_rptr_next;
  logic [PTR_WIDTH:0] w_lvl_next;
  logic               w_rd_fire;

  // Only the first stage may see g_wptr; nothing else samples the foreign-domain value.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= bus.g_wptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_g_wptr_s = r_sync[SYNC_STAGES-1];

  generate
    for (genvar gi = 0; gi <= PTR_WIDTH; gi++) begin : g_gray2bin
      assign w_b_wptr_s[gi] = ^w_g_wptr_s[PTR_WIDTH:gi];
    end
  endgenerate

  assign w_rd_fire     = bus.r_en & ~r_empty;
  assign w_b_rptr_next = r_b_rptr + {{PTR_WIDTH{1'b0}}, w_rd_fire};
  assign w_g_rptr_next = (w_b_rptr_next >> 1) ^ w_b_rptr_next;
  // Modular subtraction keeps the level right across pointer wrap.
  assign w_lvl_next    = w_b_wptr_s - w_b_rptr_next;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_b_rptr       <= '0;
      r_g_rptr       <= '0;
      r_rd_level     <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
    end else begin
      r_b_rptr       <= w_b_rptr_next;
      r_g_rptr       <= w_g_rptr_next;
      r_rd_level     <= w_lvl_next;
      r_empty        <= (w_g_rptr_next == w_g_wptr_s);
      r_almost_empty <= (w_lvl_next <= AE_LIMIT);
    end
  end

`ifdef RPTR_UNDERFLOW_EN
  logic r_underflow;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= r_underflow | (bus.r_en & r_empty);
    end
  end

  assign bus.underflow = r_underflow;
`endif

  assign bus.b_rptr       = r_b_rptr;
  assign bus.g_rptr       = r_g_rptr;
  assign bus.rd_level     = r_rd_level;
  assign bus.empty        = r_empty;
  assign bus.almost_empty = r_almost_empty;
endmodule

// File: tb/tb_rptr_level_h.sv
// Directed bench for rptr_level_h (PTR_WIDTH=3, SYNC_STAGES=2, AE_THRESH=2): a count-based
// FIFO model is checked every cycle, plus literal expectations at the key points.
module tb_rptr_level_h;
  localparam int PW   = 3;
  localparam int SYNC = 2;
  localparam int AE   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rptr_level_h_if #(.PTR_WIDTH(PW)) bus ();

  rptr_level_h #(.PTR_WIDTH(PW), .SYNC_STAGES(SYNC), .AE_THRESH(AE)) dut (
    .rclk (clk),
    .rrst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: total writes published, total reads taken, and the writes count as seen
  // through the synchroniser delay.
  int wcount;
  int rcount;
  int pipe [SYNC];
  int m_level;
  bit m_empty;
  bit m_uf;
  bit check_en = 1'b0;

  function automatic logic [PW:0] gray(input int v);
    logic [PW:0] b;
    b = v[PW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_writes(input int n);
    wcount = n;
    bus.g_wptr = gray(wcount);
  endtask

  task automatic tick();
    int seen;
    @(posedge clk);
    seen = pipe[SYNC-1];
    for (int i = SYNC-1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = wcount;
    if (bus.r_en && m_empty) m_uf = 1'b1;
    if (bus.r_en && !m_empty) rcount++;
    m_level = seen - rcount;
    m_empty = (m_level == 0);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    check_en = 1'b0;
    bus.r_en = 1'b0;
    drive_writes(0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < SYNC; i++) pipe[i] = 0;
    rcount  = 0;
    m_level = 0;
    m_empty = 1'b1;
    m_uf    = 1'b0;
    rst      = 1'b0;
    check_en = 1'b1;
  endtask

  logic [PW:0] prev_g = '0;

  always @(negedge clk) begin
    if (check_en && !rst) begin
      chk("empty", int'(bus.empty), int'(m_empty));
      chk("rd_level", int'(bus.rd_level), m_level);
      chk("almost_empty", int'(bus.almost_empty), int'(m_level <= AE));
      chk("b_rptr", int'(bus.b_rptr), rcount % (2 ** (PW+1)));
      chk("g_rptr", int'(bus.g_rptr), int'(gray(rcount)));
      if (bus.g_rptr != prev_g)
        chk("g_rptr_onebit", $countones(bus.g_rptr ^ prev_g), 1);
`ifdef RPTR_UNDERFLOW_EN
      chk("underflow", int'(bus.underflow), int'(m_uf));
`endif
      prev_g = bus.g_rptr;
    end
  end

  initial begin
    bus.r_en   = 1'b0;
    bus.g_wptr = '0;
    wcount = 0;
    rcount = 0;

    // 1. reset values
    do_reset();
    prev_g = '0;
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_ae", int'(bus.almost_empty), 1);
    chk("rst_level", int'(bus.rd_level), 0);
    chk("rst_b_rptr", int'(bus.b_rptr), 0);
    chk("rst_g_rptr", int'(bus.g_rptr), 0);

    // 2. single write: visible exactly three edges later
    drive_writes(1);
    tick();
    chk("lat1_empty", int'(bus.empty), 1);
    tick();
    chk("lat2_empty", int'(bus.empty), 1);
    tick();
    chk("lat3_empty", int'(bus.empty), 0);
    chk("lat3_level", int'(bus.rd_level), 1);
    chk("lat3_ae", int'(bus.almost_empty), 1);

    // 3. fill to 8, then drain back-to-back
    for (int n = 2; n <= 8; n++) begin
      drive_writes(n);
      tick();
    end
    repeat (3) tick();
    chk("full_level", int'(bus.rd_level), 8);
    chk("full_ae", int'(bus.almost_empty), 0);
    bus.r_en = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk("drain_level", int'(bus.rd_level), 8 - n);
      chk("drain_ae", int'(bus.almost_empty), int'(n >= 6));
    end
    chk("drain_b_rptr", int'(bus.b_rptr), 8);
    chk("drain_empty", int'(bus.empty), 1);

    // 5. read while empty is ignored
    repeat (2) tick();
    chk("uf_b_rptr", int'(bus.b_rptr), 8);
`ifdef RPTR_UNDERFLOW_EN
    chk("uf_flag", int'(bus.underflow), 1);
`endif
    bus.r_en = 1'b0;

    // 4. mixed traffic across many pointer wraps
    for (int i = 0; i < 340; i++) begin
      if ((i % 3 != 0) && (wcount - rcount < 8)) drive_writes(wcount + 1);
      bus.r_en = ((i % 7) < 5) ? 1'b1 : 1'b0;
      tick();
    end
    bus.r_en = 1'b0;
    repeat (4) tick();
    chk("mix_level", int'(bus.rd_level), wcount - rcount);

    // 6. asynchronous reset mid-burst with rd_level = 5
    do_reset();
    prev_g = '0;
    for (int n = 1; n <= 7; n++) begin
      drive_writes(n);
      tick();
    end
    repeat (3) tick();
    bus.r_en = 1'b1;
    repeat (2) tick();
    chk("pre_rst_level", int'(bus.rd_level), 5);
    #2;
    rst = 1'b1;
    check_en = 1'b0;
    #1;
    chk("arst_empty", int'(bus.empty), 1);
    chk("arst_ae", int'(bus.almost_empty), 1);
    chk("arst_level", int'(bus.rd_level), 0);
    chk("arst_b_rptr", int'(bus.b_rptr), 0);
    chk("arst_g_rptr", int'(bus.g_rptr), 0);
`ifdef RPTR_UNDERFLOW_EN
    chk("arst_uf", int'(bus.underflow), 0);
`endif
    do_reset();
    prev_g = '0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
